// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline constants for the MEM stage: access-size encodings, FSM states and widths.
package mem_access_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 6;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } memSize_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_e;

endpackage

// File: rtl/mem_access_stage_align.sv
// mem_align_unit: big-endian store lane steering, byte enables, load extraction/extension
// and misalignment detection. Byte offset 0 is the most significant byte (data[31:24]).
module mem_align_unit
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              isSigned,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] rData,
  output logic [DATA_W-1:0] wData,
  output logic [0:3]        byteEn,
  output logic [DATA_W-1:0] loadData,
  output logic              misalign
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = rData[7:0];
    case (offset)
      2'd0:    byteLane = rData[31:24];
      2'd1:    byteLane = rData[23:16];
      2'd2:    byteLane = rData[15:8];
      default: byteLane = rData[7:0];
    endcase
    halfLane = offset[1] ? rData[15:0] : rData[31:16];
  end

  // byteEn[0] enables the offset-0 lane, so the literals read left-to-right as offsets 0..3
  always_comb begin
    wData    = '0;
    byteEn   = '0;
    loadData = '0;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wData = {4{storeData[7:0]}};
        case (offset)
          2'd0:    byteEn = 4'b1000;
          2'd1:    byteEn = 4'b0100;
          2'd2:    byteEn = 4'b0010;
          default: byteEn = 4'b0001;
        endcase
        loadData = {{24{isSigned & byteLane[7]}}, byteLane};
      end
      SIZE_HALF: begin
        misalign = offset[0];
        wData    = {2{storeData[15:0]}};
        byteEn   = offset[1] ? 4'b0011 : 4'b1100;
        loadData = {{16{isSigned & halfLane[15]}}, halfLane};
      end
      SIZE_WORD: begin
        misalign = |offset;
        wData    = storeData;
        byteEn   = 4'b1111;
        loadData = rData;
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) byteEn = '0;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory request FSM and MEM/WB outputs.
// Optional access timeout is enabled with MEM_TIMEOUT_EN (adds MemTimeout port).
//
// state | meaning
// IDLE  | no access outstanding; a fresh latched load/store is issued combinationally
// WAIT  | access issued, waiting for DMemAck; request held stable, MemStall asserted
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [DATA_W-1:0]     NextALUOut,
  input  logic [DATA_W-1:0]     NextStoreData,
  input  logic                  NextMemRead,
  input  logic                  NextMemWrite,
  input  logic [1:0]            NextMemSize,
  input  logic                  NextMemSigned,
  input  logic [DATA_W-1:0]     NextFPUOut,
  input  logic [DATA_W-1:0]     NextPCPlusFour,
  input  logic [5:0]            NextOpcode,
  input  logic [5:0]            NextFunct,
  input  logic [15:0]           NextImmediate,
  input  logic [1:0]            NextDInSrc,
  input  logic                  NextRegWE,
  input  logic [REG_ADDR_W-1:0] NextRegWAddr,
  output logic [ADDR_W-1:0]     DMemAddr,
  output logic [DATA_W-1:0]     DMemWData,
  output logic [0:3]            DMemByteEn,
  output logic                  DMemRE,
  output logic                  DMemWE,
  input  logic                  DMemAck,
  input  logic [DATA_W-1:0]     DMemRData,
  output logic [DATA_W-1:0]     WbALUOut,
  output logic [DATA_W-1:0]     WbFPUOut,
  output logic [DATA_W-1:0]     WbMEMDout,
  output logic [DATA_W-1:0]     WbPCPlusFour,
  output logic [5:0]            WbOpcode,
  output logic [5:0]            WbFunct,
  output logic [15:0]           WbImmediate,
  output logic [1:0]            WbDInSrc,
  output logic                  WbRegWE,
  output logic [REG_ADDR_W-1:0] WbRegWAddr,
  output logic                  MemStall,
  output logic                  MisalignFault
`ifdef MEM_TIMEOUT_EN
  , output logic                MemTimeout
`endif
);

  logic [DATA_W-1:0]     exALUOut, exStoreData, exFPUOut, exPCPlusFour;
  logic                  exMemRead, exMemWrite, exMemSigned, exRegWE;
  logic [1:0]            exMemSize, exDInSrc;
  logic [5:0]            exOpcode, exFunct;
  logic [15:0]           exImmediate;
  logic [REG_ADDR_W-1:0] exRegWAddr;

  memState_e         state, nextState;
  logic              accDone, faultSeen;
  logic [DATA_W-1:0] loadDataQ;

  logic              isLoad, isStore, pending, loadEn;
  logic              accessDone, timeoutNow;
  logic [DATA_W-1:0] alignWData, alignLoad;
  logic [0:3]        alignByteEn;
  logic              misalign;

  // A store wins when both read and write are flagged.
  assign isStore = exMemWrite;
  assign isLoad  = exMemRead & ~exMemWrite;
  // accDone keeps a held instruction from re-issuing or re-faulting while stalled.
  assign pending = (exMemRead | exMemWrite) & ~accDone;
  assign loadEn  = ~stall & ~MemStall;

  mem_align_unit u_align (
    .offset    (exALUOut[1:0]),
    .size      (exMemSize),
    .isSigned  (exMemSigned),
    .storeData (exStoreData),
    .rData     (DMemRData),
    .wData     (alignWData),
    .byteEn    (alignByteEn),
    .loadData  (alignLoad),
    .misalign  (misalign)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] toCnt;
  logic             toTerminal;

  assign toTerminal = (toCnt == '0);
  assign MemTimeout = timeoutNow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      toCnt <= '0;
    else if (state == IDLE && nextState == WAIT)
      toCnt <= TO_LOAD;
    else if (state == WAIT && nextState == WAIT)
      toCnt <= toCnt - 1'b1;
    else
      toCnt <= '0;
  end
`endif

  always_comb begin
    nextState     = state;
    DMemRE        = 1'b0;
    DMemWE        = 1'b0;
    MemStall      = 1'b0;
    MisalignFault = 1'b0;
    accessDone    = 1'b0;
    timeoutNow    = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          if (misalign) begin
            MisalignFault = 1'b1;
          end else begin
            DMemRE = isLoad;
            DMemWE = isStore;
            if (DMemAck) begin
              accessDone = 1'b1;
            end else begin
              MemStall  = 1'b1;
              nextState = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (DMemAck) begin
          DMemRE     = isLoad;
          DMemWE     = isStore;
          accessDone = 1'b1;
          nextState  = IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (toTerminal) begin
          timeoutNow = 1'b1;
          nextState  = IDLE;
`endif
        end else begin
          DMemRE   = isLoad;
          DMemWE   = isStore;
          MemStall = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      exALUOut     <= '0;
      exStoreData  <= '0;
      exMemRead    <= 1'b0;
      exMemWrite   <= 1'b0;
      exMemSize    <= '0;
      exMemSigned  <= 1'b0;
      exFPUOut     <= '0;
      exPCPlusFour <= '0;
      exOpcode     <= '0;
      exFunct      <= '0;
      exImmediate  <= '0;
      exDInSrc     <= '0;
      exRegWE      <= 1'b0;
      exRegWAddr   <= '0;
      accDone      <= 1'b0;
      faultSeen    <= 1'b0;
      loadDataQ    <= '0;
    end else begin
      state <= nextState;
      if (loadEn) begin
        exALUOut     <= NextALUOut;
        exStoreData  <= NextStoreData;
        exMemRead    <= NextMemRead;
        exMemWrite   <= NextMemWrite;
        exMemSize    <= NextMemSize;
        exMemSigned  <= NextMemSigned;
        exFPUOut     <= NextFPUOut;
        exPCPlusFour <= NextPCPlusFour;
        exOpcode     <= NextOpcode;
        exFunct      <= NextFunct;
        exImmediate  <= NextImmediate;
        exDInSrc     <= NextDInSrc;
        exRegWE      <= NextRegWE;
        exRegWAddr   <= NextRegWAddr;
        accDone      <= 1'b0;
        faultSeen    <= 1'b0;
        loadDataQ    <= '0;
      end else begin
        if (accessDone) begin
          accDone <= 1'b1;
          if (isLoad) loadDataQ <= alignLoad;
        end
        if (MisalignFault | timeoutNow) begin
          accDone   <= 1'b1;
          faultSeen <= 1'b1;
        end
      end
    end
  end

  assign DMemAddr   = {exALUOut[ADDR_W-1:2], 2'b00};
  assign DMemWData  = alignWData;
  assign DMemByteEn = (DMemRE | DMemWE) ? alignByteEn : '0;

  assign WbALUOut     = exALUOut;
  assign WbFPUOut     = exFPUOut;
  assign WbPCPlusFour = exPCPlusFour;
  assign WbOpcode     = exOpcode;
  assign WbFunct      = exFunct;
  assign WbImmediate  = exImmediate;
  assign WbDInSrc     = exDInSrc;
  assign WbRegWAddr   = exRegWAddr;
  assign WbMEMDout    = (accessDone & isLoad) ? alignLoad : loadDataQ;
  assign WbRegWE      = exRegWE & ~MemStall & ~faultSeen & ~MisalignFault & ~timeoutNow;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; covers the timeout path when
// built with MEM_TIMEOUT_EN (TIMEOUT_CYCLES overridden to 4).
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] NextALUOut, NextStoreData, NextFPUOut, NextPCPlusFour;
  logic        NextMemRead, NextMemWrite, NextMemSigned, NextRegWE;
  logic [1:0]  NextMemSize, NextDInSrc;
  logic [5:0]  NextOpcode, NextFunct, NextRegWAddr;
  logic [15:0] NextImmediate;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [0:3]  DMemByteEn;
  logic        DMemRE, DMemWE, DMemAck;
  logic [31:0] WbALUOut, WbFPUOut, WbMEMDout, WbPCPlusFour;
  logic [5:0]  WbOpcode, WbFunct, WbRegWAddr;
  logic [15:0] WbImmediate;
  logic [1:0]  WbDInSrc;
  logic        WbRegWE, MemStall, MisalignFault;
`ifdef MEM_TIMEOUT_EN
  logic        MemTimeout;
`endif

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ADDR_W(32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .NextALUOut(NextALUOut), .NextStoreData(NextStoreData),
    .NextMemRead(NextMemRead), .NextMemWrite(NextMemWrite),
    .NextMemSize(NextMemSize), .NextMemSigned(NextMemSigned),
    .NextFPUOut(NextFPUOut), .NextPCPlusFour(NextPCPlusFour),
    .NextOpcode(NextOpcode), .NextFunct(NextFunct),
    .NextImmediate(NextImmediate), .NextDInSrc(NextDInSrc),
    .NextRegWE(NextRegWE), .NextRegWAddr(NextRegWAddr),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemByteEn(DMemByteEn),
    .DMemRE(DMemRE), .DMemWE(DMemWE), .DMemAck(DMemAck), .DMemRData(DMemRData),
    .WbALUOut(WbALUOut), .WbFPUOut(WbFPUOut), .WbMEMDout(WbMEMDout),
    .WbPCPlusFour(WbPCPlusFour), .WbOpcode(WbOpcode), .WbFunct(WbFunct),
    .WbImmediate(WbImmediate), .WbDInSrc(WbDInSrc), .WbRegWE(WbRegWE),
    .WbRegWAddr(WbRegWAddr), .MemStall(MemStall), .MisalignFault(MisalignFault)
`ifdef MEM_TIMEOUT_EN
    , .MemTimeout(MemTimeout)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic nop();
    NextALUOut = '0; NextStoreData = '0; NextMemRead = 1'b0; NextMemWrite = 1'b0;
    NextMemSize = '0; NextMemSigned = 1'b0; NextFPUOut = '0; NextPCPlusFour = '0;
    NextOpcode = '0; NextFunct = '0; NextImmediate = '0; NextDInSrc = '0;
    NextRegWE = 1'b0; NextRegWAddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, latch it on the next edge, then fall back to NOP inputs.
  task automatic launch(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic we, input logic [5:0] wa);
    NextMemRead = rd; NextMemWrite = wr; NextMemSize = sz; NextMemSigned = sgn;
    NextALUOut = addr; NextStoreData = sd; NextRegWE = we; NextRegWAddr = wa;
    tick();
    nop();
    DMemAck = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; DMemAck = 1'b0; DMemRData = '0;
    nop();
    NextRegWE = 1'b1; NextALUOut = 32'h0000_1234; NextMemRead = 1'b1;
    #12;
    checkVal("rst DMemRE", DMemRE, 0);
    checkVal("rst MemStall", MemStall, 0);
    checkVal("rst WbRegWE", WbRegWE, 0);
    checkVal("rst WbALUOut", WbALUOut, 0);
    checkVal("rst DMemAddr", DMemAddr, 0);
    checkVal("rst WbMEMDout", WbMEMDout, 0);
    reset = 1'b0;
    nop();

    // word load, same-cycle ack, plus pass-through fields
    NextFPUOut = 32'hCAFE_F00D; NextOpcode = 6'h23; NextPCPlusFour = 32'h0000_1004;
    launch(1, 0, SIZE_WORD, 0, 32'h100, 0, 1, 6'd5);
    DMemAck = 1'b1; DMemRData = 32'hDEAD_BEEF;
    #4;
    checkVal("lw DMemRE", DMemRE, 1);
    checkVal("lw MemStall", MemStall, 0);
    checkVal("lw WbMEMDout", WbMEMDout, 32'hDEAD_BEEF);
    checkVal("lw ByteEn", DMemByteEn, 4'b1111);
    checkVal("lw DMemAddr", DMemAddr, 32'h100);
    checkVal("lw WbRegWE", WbRegWE, 1);
    checkVal("lw WbRegWAddr", WbRegWAddr, 5);
    checkVal("lw WbFPUOut", WbFPUOut, 32'hCAFE_F00D);
    checkVal("lw WbOpcode", WbOpcode, 6'h23);
    checkVal("lw WbPCPlusFour", WbPCPlusFour, 32'h1004);
    tick();
    DMemAck = 1'b0;
    #4;
    checkVal("nop DMemRE", DMemRE, 0);
    checkVal("nop WbMEMDout", WbMEMDout, 0);
    checkVal("nop ByteEn", DMemByteEn, 0);

    // signed / unsigned byte loads, signed half load
    launch(1, 0, SIZE_BYTE, 1, 32'h103, 0, 1, 6'd1);
    DMemAck = 1'b1; DMemRData = 32'h0000_00F0;
    #4;
    checkVal("lbs WbMEMDout", WbMEMDout, 32'hFFFF_FFF0);
    checkVal("lbs ByteEn", DMemByteEn, 4'b0001);
    checkVal("lbs DMemAddr", DMemAddr, 32'h100);
    launch(1, 0, SIZE_BYTE, 0, 32'h103, 0, 1, 6'd1);
    DMemAck = 1'b1; DMemRData = 32'h0000_00F0;
    #4;
    checkVal("lbu WbMEMDout", WbMEMDout, 32'h0000_00F0);
    launch(1, 0, SIZE_HALF, 1, 32'h102, 0, 1, 6'd1);
    DMemAck = 1'b1; DMemRData = 32'h1234_8001;
    #4;
    checkVal("lhs WbMEMDout", WbMEMDout, 32'hFFFF_8001);
    checkVal("lhs ByteEn", DMemByteEn, 4'b0011);

    // byte store and store-wins-over-load
    launch(0, 1, SIZE_BYTE, 0, 32'h201, 32'h0000_00A5, 0, 6'd0);
    DMemAck = 1'b1;
    #4;
    checkVal("sb DMemWData", DMemWData, 32'hA5A5_A5A5);
    checkVal("sb ByteEn", DMemByteEn, 4'b0100);
    checkVal("sb DMemWE", DMemWE, 1);
    launch(1, 1, SIZE_WORD, 0, 32'h600, 32'h7777_8888, 0, 6'd0);
    DMemAck = 1'b1;
    #4;
    checkVal("rw DMemWE", DMemWE, 1);
    checkVal("rw DMemRE", DMemRE, 0);

    // half store, ack after three stall cycles
    launch(0, 1, SIZE_HALF, 0, 32'h202, 32'h1234_ABCD, 1, 6'd7);
    for (int i = 0; i < 4; i++) begin
      DMemAck = (i == 3);
      #4;
      checkVal($sformatf("sh[%0d] DMemWData", i), DMemWData, 32'hABCD_ABCD);
      checkVal($sformatf("sh[%0d] ByteEn", i), DMemByteEn, 4'b0011);
      checkVal($sformatf("sh[%0d] DMemWE", i), DMemWE, 1);
      checkVal($sformatf("sh[%0d] DMemAddr", i), DMemAddr, 32'h200);
      checkVal($sformatf("sh[%0d] MemStall", i), MemStall, (i < 3) ? 1 : 0);
      checkVal($sformatf("sh[%0d] WbRegWE", i), WbRegWE, (i == 3) ? 1 : 0);
      checkVal($sformatf("sh[%0d] WbRegWAddr", i), WbRegWAddr, 7);
      tick();
    end
    DMemAck = 1'b0;
    #4;
    checkVal("sh after DMemWE", DMemWE, 0);

    // misaligned word load, held one extra cycle by stall
    launch(1, 0, SIZE_WORD, 0, 32'h101, 0, 1, 6'd3);
    stall = 1'b1;
    #4;
    checkVal("mis DMemRE", DMemRE, 0);
    checkVal("mis MisalignFault", MisalignFault, 1);
    checkVal("mis WbRegWE", WbRegWE, 0);
    checkVal("mis MemStall", MemStall, 0);
    tick();
    #4;
    checkVal("mis2 MisalignFault", MisalignFault, 0);
    checkVal("mis2 WbRegWE", WbRegWE, 0);
    checkVal("mis2 DMemRE", DMemRE, 0);
    stall = 1'b0;
    tick();

    // load data held stable while stalled after ack
    launch(1, 0, SIZE_WORD, 0, 32'h104, 0, 1, 6'd2);
    stall = 1'b1; DMemAck = 1'b1; DMemRData = 32'h1122_3344;
    #4;
    checkVal("hold WbMEMDout", WbMEMDout, 32'h1122_3344);
    checkVal("hold WbRegWE", WbRegWE, 1);
    tick();
    DMemAck = 1'b0; DMemRData = 32'hFFFF_FFFF;
    #4;
    checkVal("hold2 DMemRE", DMemRE, 0);
    checkVal("hold2 WbMEMDout", WbMEMDout, 32'h1122_3344);
    checkVal("hold2 WbRegWAddr", WbRegWAddr, 2);
    stall = 1'b0;
    tick();
    #4;
    checkVal("hold3 WbMEMDout", WbMEMDout, 0);

    // reset in WAIT, then a normal load
    launch(1, 0, SIZE_WORD, 0, 32'h300, 0, 1, 6'd4);
    #4;
    checkVal("rw0 MemStall", MemStall, 1);
    tick();
    #4;
    checkVal("rw1 DMemRE", DMemRE, 1);
    reset = 1'b1;
    #1;
    checkVal("rstw DMemRE", DMemRE, 0);
    checkVal("rstw MemStall", MemStall, 0);
    checkVal("rstw WbALUOut", WbALUOut, 0);
    checkVal("rstw WbRegWAddr", WbRegWAddr, 0);
    checkVal("rstw DMemAddr", DMemAddr, 0);
    tick();
    reset = 1'b0;
    launch(1, 0, SIZE_WORD, 0, 32'h400, 0, 1, 6'd6);
    DMemAck = 1'b1; DMemRData = 32'h55AA_55AA;
    #4;
    checkVal("post DMemRE", DMemRE, 1);
    checkVal("post DMemAddr", DMemAddr, 32'h400);
    checkVal("post WbMEMDout", WbMEMDout, 32'h55AA_55AA);
    checkVal("post MemStall", MemStall, 0);
    checkVal("post WbRegWE", WbRegWE, 1);
    tick();
    DMemAck = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // ack never arrives: timeout on the fourth WAIT cycle
    launch(1, 0, SIZE_WORD, 0, 32'h500, 0, 1, 6'd8);
    for (int i = 0; i < 5; i++) begin
      #4;
      checkVal($sformatf("to[%0d] MemTimeout", i), MemTimeout, (i == 4) ? 1 : 0);
      checkVal($sformatf("to[%0d] MemStall", i), MemStall, (i < 4) ? 1 : 0);
      checkVal($sformatf("to[%0d] DMemRE", i), DMemRE, (i < 4) ? 1 : 0);
      checkVal($sformatf("to[%0d] WbRegWE", i), WbRegWE, 0);
      tick();
    end
    #4;
    checkVal("to after MemTimeout", MemTimeout, 0);
    checkVal("to after WbALUOut", WbALUOut, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the pipeline, between the execute stage and the write-back stage.
- Latches the EX/MEM pipeline register and drives the data-memory request/ack interface.
- Aligns load data with sign or zero extension, and steers store data onto byte lanes.
- Presents MEM/WB "Next*" values to write-back and raises MemStall while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYCLES, 16, maximum wait for DMemAck; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit freeze; pipeline register holds
- NextALUOut  in  32  effective address or ALU result
- NextStoreData  in  32  rt value for stores
- NextMemRead  in  1  load
- NextMemWrite  in  1  store
- NextMemSize  in  2  00 byte, 01 half, 10 word, 11 reserved
- NextMemSigned  in  1  sign-extend loads
- NextFPUOut, NextPCPlusFour  in  32 each  pass-through
- NextOpcode, NextFunct  in  6 each  pass-through
- NextImmediate  in  16  pass-through
- NextDInSrc  in  2  pass-through
- NextRegWE  in  1  pass-through
- NextRegWAddr  in  6  pass-through
- DMemAddr  out  ADDR_W  word-aligned address (low 2 bits 0)
- DMemWData  out  32  lane-steered store data
- DMemByteEn  out  4  lane enables, index 0 = bits [0:7]
- DMemRE, DMemWE  out  1 each  request strobes
- DMemAck  in  1  access complete; read data valid
- DMemRData  in  32  read data
- WbALUOut, WbFPUOut, WbMEMDout, WbPCPlusFour  out  32 each  to write-back
- WbOpcode, WbFunct  out  6 each  to write-back
- WbImmediate  out  16  to write-back
- WbDInSrc  out  2  to write-back
- WbRegWE  out  1  to write-back
- WbRegWAddr  out  6  to write-back
- MemStall  out  1  to hazard unit
- MisalignFault  out  1  one-cycle pulse

Behaviour:
- Bit ordering: bit 0 is the MSB. Big-endian lanes: byte offset 0 maps to bits [0:7].
- Pipeline register:
  - Loads all Next* inputs on posedge clk when stall=0 and MemStall=0; otherwise holds.
  - Reset clears every register to 0, FSM to IDLE, and every output to 0.
- FSM states: IDLE, WAIT.
  - IDLE with a latched load or store: assert DMemRE or DMemWE combinationally.
    - DMemAck=1 in the same cycle: access completes, MemStall=0, zero extra latency.
    - DMemAck=0: MemStall=1 combinationally and go to WAIT.
  - WAIT: hold addr, data, byte enables and strobes stable, MemStall=1. On DMemAck=1, return to IDLE with MemStall=0 that cycle.
  - Reset in WAIT: return to IDLE immediately and drop the strobes.
- Bubble: while MemStall=1, WbRegWE=0 so write-back never commits a stale result. All other Wb* outputs follow the held register.
- Alignment check:
  - Half access with addr[31]=1: misaligned.
  - Word access with addr[30:31]≠0: misaligned.
  - Size 11: misaligned.
  - On misalignment: no strobe, MisalignFault=1 for one cycle, WbRegWE=0, no stall.
- Store steering:
  - Byte: replicate StoreData[24:31] on all lanes; DMemByteEn one-hot at the offset.
  - Half: replicate StoreData[16:31]; enables 1100 or 0011.
  - Word: data as-is; enables 1111.
- Load extraction:
  - Select the lane(s) from DMemRData; sign- or zero-extend per MemSigned.
  - WbMEMDout is combinational from DMemRData in the ack cycle.
  - Loaded data is also captured into an internal register, so WbMEMDout stays stable while stall=1 after ack.
- A latched instruction that is neither load nor store: no strobe, no stall, WbMEMDout=0.
- If NextMemRead and NextMemWrite are both set, the store wins.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without ack aborts the access: strobes drop, state returns to IDLE, MemStall=0, WbRegWE=0.
  - Output port MemTimeout (1 bit) pulses for one cycle.
  - The counter clears on ack, on leaving WAIT and on reset.
- Undefined: no counter and no MemTimeout port; WAIT lasts until DMemAck.

Decomposition:
- Shared package (pipeline constants file):
  - MemSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - FSM state constants.
  - Data width 32 and register-address width 6.
- One natural sub-module, mem_align_unit (combinational): store lane steering, byte enables, load extraction and extension, misalignment detection.
- The FSM and pipeline register stay in mem_access_stage.

Test Plan:
- Word load, addr 0x100, ack in the same cycle, DMemRData=0xDEADBEEF -> MemStall never set; WbMEMDout=0xDEADBEEF; DMemByteEn=1111.
- Signed byte load, addr 0x103, DMemRData=0x000000F0 -> WbMEMDout=0xFFFFFFF0. Unsigned version -> 0x000000F0.
- Half store, addr 0x202, StoreData=0x1234ABCD, ack after 3 cycles:
  - DMemWData=0xABCDABCD and DMemByteEn=0011, both stable for 4 cycles.
  - MemStall=1 for 3 cycles; WbRegWE=0 during the stall.
- Word load at 0x101 -> no strobe, MisalignFault pulses once, WbRegWE=0.
- Reset asserted mid-WAIT -> DMemRE=0, MemStall=0 and all Wb*=0 immediately; next load proceeds normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never arrives -> MemTimeout pulses at cycle 4 of WAIT, then MemStall=0 and the pipeline advances.
